// File: rtl/ifetch_ctrl_pkg.sv
// Shared fetch-side types: next-PC select encodings, fetch FSM states,
// and the IF/ID bundle held by the fetch buffer.
package ifetch_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_4      = 2'b00,
        PC_IMM    = 2'b01,
        PC_IMMRS1 = 2'b10,
        PC_RSVD   = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        REQ   = 2'b01,
        WAIT  = 2'b10,
        DRAIN = 2'b11
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch bus: instruction-memory request/response plus the IF->ID
// instruction handoff and the decode stall that back-pressures it.
interface ifetch_ctrl_if;

    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;

    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    modport master (
        output im_req,
        output im_addr,
        input  im_gnt,
        input  im_rvalid,
        input  im_rdata,
        input  stall,
        output if_valid,
        output if_pc,
        output if_inst
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_gnt,
        output im_rvalid,
        output im_rdata,
        output stall,
        input  if_valid,
        input  if_pc,
        input  if_inst
    );

endinterface

// File: rtl/ifetch_buf.sv
// One-entry IF/ID holding register: clear beats load beats consume, so
// a response arriving on the consume cycle refills it without a bubble.
module ifetch_buf
    import ifetch_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   consume,
    input  logic   clear,
    input  if_id_t din,
    output logic   valid,
    output if_id_t dout
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (clear) begin
            valid     <= 1'b0;
            dout.inst <= NOP;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: single-outstanding fetch FSM with
// EX redirect handling, response drain and a 1-entry IF/ID buffer.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    input  logic [1:0]    branch_ctrl,
    input  logic [31:0]   pc_imm,
    input  logic [31:0]   pc_immrs1,
    output logic          flush,
    ifetch_ctrl_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q, req_pc_d;

    logic         redirect;
    logic [31:0]  target;
    logic         req;
    logic         accept;
    logic         buf_valid;
    logic         buf_load;
    logic         buf_consume;
    if_id_t       buf_din;
    if_id_t       buf_dout;

    always_comb begin
        redirect = 1'b0;
        target   = '0;
        if (ex_valid) begin
            unique case (pc_sel_e'(branch_ctrl))
                PC_IMM: begin
                    redirect = 1'b1;
                    target   = align_pc(pc_imm);
                end
                PC_IMMRS1: begin
                    redirect = 1'b1;
                    target   = align_pc(pc_immrs1);
                end
                default: ;
            endcase
        end
    end

    // A full buffer that decode is not draining must not be overrun
    // by the response to a new request, so hold the request back.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        req        = 1'b0;
        buf_load   = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d    = REQ;
                fetch_pc_d = RESET_PC;
            end
            REQ: begin
                req = ~(buf_valid & bus.stall);
                if (redirect) begin
                    fetch_pc_d = target;
                    if (req && bus.im_gnt) state_d = DRAIN;
                end else if (req && bus.im_gnt) begin
                    req_pc_d = fetch_pc_q;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    state_d    = bus.im_rvalid ? REQ : DRAIN;
                end else if (bus.im_rvalid) begin
                    buf_load   = 1'b1;
                    fetch_pc_d = req_pc_q + 32'd4;
                    state_d    = REQ;
                end
            end
            DRAIN: begin
                if (redirect) fetch_pc_d = target;
                if (bus.im_rvalid) state_d = REQ;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            flush      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            flush      <= redirect;
        end
    end

    assign accept      = req & bus.im_gnt;
    assign buf_consume = buf_valid & ~bus.stall;
    assign buf_din     = '{pc: req_pc_q, inst: bus.im_rdata};

    ifetch_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (buf_load),
        .consume (buf_consume),
        .clear   (redirect),
        .din     (buf_din),
        .valid   (buf_valid),
        .dout    (buf_dout)
    );

    assign bus.im_req   = req;
    assign bus.im_addr  = fetch_pc_q;
    assign bus.if_valid = buf_valid;
    assign bus.if_pc    = buf_dout.pc;
    assign bus.if_inst  = buf_dout.inst;

    logic unused_accept;
    assign unused_accept = accept;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a fixed-latency memory model
// whose read data is address + 32'h1000_0000.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [1:0]  branch_ctrl;
    logic [31:0] pc_imm;
    logic [31:0] pc_immrs1;
    logic        flush;

    always #5 clk = ~clk;

    ifetch_ctrl_if bus ();

    ifetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .branch_ctrl (branch_ctrl),
        .pc_imm      (pc_imm),
        .pc_immrs1   (pc_immrs1),
        .flush       (flush),
        .bus         (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int resp_delay = 1;
    int flush_cnt;

    logic [31:0] acc_q[$];
    logic [31:0] dpc_q[$];
    logic [31:0] dinst_q[$];

    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    always @(posedge clk) begin
        if (!rst_n) begin
            mem_busy      <= 1'b0;
            mem_cnt       <= 0;
            mem_addr      <= '0;
            bus.im_rvalid <= 1'b0;
            bus.im_rdata  <= '0;
        end else begin
            bus.im_rvalid <= 1'b0;
            if (mem_busy) begin
                if (mem_cnt <= 1) begin
                    bus.im_rvalid <= 1'b1;
                    bus.im_rdata  <= mem_addr + 32'h1000_0000;
                    mem_busy      <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end
            if (bus.im_req && bus.im_gnt) begin
                mem_busy <= 1'b1;
                mem_addr <= bus.im_addr;
                mem_cnt  <= resp_delay;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_q.delete();
            dpc_q.delete();
            dinst_q.delete();
            flush_cnt = 0;
        end else begin
            if (bus.im_req && bus.im_gnt) acc_q.push_back(bus.im_addr);
            if (bus.if_valid && !bus.stall) begin
                dpc_q.push_back(bus.if_pc);
                dinst_q.push_back(bus.if_inst);
            end
            if (flush) flush_cnt = flush_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic wait_acc(input int n);
        for (int k = 0; k < 300 && acc_q.size() < n; k++) begin
            @(negedge clk);
            #1;
        end
        if (acc_q.size() < n)
            chk("acc_timeout", 32'(acc_q.size()), 32'(n));
    endtask

    task automatic wait_dq(input int n);
        for (int k = 0; k < 300 && dpc_q.size() < n; k++) begin
            @(negedge clk);
            #1;
        end
        if (dpc_q.size() < n)
            chk("dq_timeout", 32'(dpc_q.size()), 32'(n));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        ex_valid    = 1'b0;
        branch_ctrl = 2'b00;
        pc_imm      = '0;
        pc_immrs1   = '0;
        bus.stall   = 1'b0;
        bus.im_gnt  = 1'b1;
        resp_delay  = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic redir(input logic [1:0] bc, input logic [31:0] imm,
                         input logic [31:0] rs1);
        @(posedge clk);
        #1;
        ex_valid    = 1'b1;
        branch_ctrl = bc;
        pc_imm      = imm;
        pc_immrs1   = rs1;
        @(posedge clk);
        #1;
        ex_valid    = 1'b0;
        branch_ctrl = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        ex_valid    = 1'b0;
        branch_ctrl = 2'b00;
        pc_imm      = '0;
        pc_immrs1   = '0;
        bus.stall   = 1'b0;
        bus.im_gnt  = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_im_req", 32'(bus.im_req), 32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_if_inst", bus.if_inst, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // sequential fetch
        wait_acc(3);
        chk("seq_a0", acc_q[0], 32'h0000_0000);
        chk("seq_a1", acc_q[1], 32'h0000_0004);
        chk("seq_a2", acc_q[2], 32'h0000_0008);
        wait_dq(2);
        chk("seq_pc0", dpc_q[0], 32'h0000_0000);
        chk("seq_in0", dinst_q[0], 32'h1000_0000);
        chk("seq_pc1", dpc_q[1], 32'h0000_0004);
        chk("seq_in1", dinst_q[1], 32'h1000_0004);

        // stall while the response arrives
        do_reset();
        wait_acc(1);
        chk("stl_a0", acc_q[0], 32'h0000_0000);
        @(posedge clk);
        #1;
        bus.stall = 1'b1;
        repeat (4) @(negedge clk);
        chk("stl_valid", 32'(bus.if_valid), 32'd1);
        chk("stl_pc", bus.if_pc, 32'h0000_0000);
        chk("stl_inst", bus.if_inst, 32'h1000_0000);
        chk("stl_noreq", 32'(bus.im_req), 32'd0);
        #1;
        chk("stl_nacc", 32'(acc_q.size()), 32'd1);
        chk("stl_ndq", 32'(dpc_q.size()), 32'd0);
        @(posedge clk);
        #1;
        bus.stall = 1'b0;
        wait_acc(2);
        chk("stl_a1", acc_q[1], 32'h0000_0004);
        wait_dq(1);
        chk("stl_dpc", dpc_q[0], 32'h0000_0000);
        chk("stl_din", dinst_q[0], 32'h1000_0000);

        // PC_IMM redirect while waiting: drain the stale response
        do_reset();
        resp_delay = 3;
        wait_acc(1);
        redir(2'b01, 32'h0000_0100, 32'h0);
        @(negedge clk);
        chk("wr_flush1", 32'(flush), 32'd1);
        chk("wr_drainreq", 32'(bus.im_req), 32'd0);
        @(negedge clk);
        chk("wr_flush0", 32'(flush), 32'd0);
        wait_acc(2);
        chk("wr_a1", acc_q[1], 32'h0000_0100);
        chk("wr_nostale", 32'(dpc_q.size()), 32'd0);
        wait_dq(1);
        chk("wr_dpc", dpc_q[0], 32'h0000_0100);
        chk("wr_din", dinst_q[0], 32'h1000_0100);
        chk("wr_fcnt", 32'(flush_cnt), 32'd1);

        // PC_IMMRS1 target has its low bits cleared
        do_reset();
        wait_acc(1);
        redir(2'b10, 32'h0, 32'h0000_0203);
        wait_acc(2);
        chk("rs1_a1", acc_q[1], 32'h0000_0200);
        chk("rs1_ndq", 32'(dpc_q.size()), 32'd0);

        // redirect coinciding with the response goes straight to REQ
        do_reset();
        wait_acc(1);
        @(posedge clk);
        redir(2'b01, 32'h0000_0306, 32'h0);
        wait_acc(2);
        chk("rv_a1", acc_q[1], 32'h0000_0304);
        chk("rv_ndq", 32'(dpc_q.size()), 32'd0);
        wait_dq(1);
        chk("rv_dpc", dpc_q[0], 32'h0000_0304);

        // second redirect during DRAIN overrides the first
        do_reset();
        resp_delay = 3;
        wait_acc(1);
        @(posedge clk);
        #1;
        ex_valid    = 1'b1;
        branch_ctrl = 2'b01;
        pc_imm      = 32'h0000_0040;
        @(posedge clk);
        #1;
        pc_imm = 32'h0000_0080;
        @(posedge clk);
        #1;
        ex_valid    = 1'b0;
        branch_ctrl = 2'b00;
        wait_acc(2);
        chk("dd_a1", acc_q[1], 32'h0000_0080);
        chk("dd_fcnt", 32'(flush_cnt), 32'd2);

        // 32-bit PC wrap
        do_reset();
        wait_acc(1);
        redir(2'b01, 32'hFFFF_FFFC, 32'h0);
        wait_acc(3);
        chk("wrap_a1", acc_q[1], 32'hFFFF_FFFC);
        chk("wrap_a2", acc_q[2], 32'h0000_0000);
        wait_dq(1);
        chk("wrap_dpc", dpc_q[0], 32'hFFFF_FFFC);
        chk("wrap_din", dinst_q[0], 32'h0FFF_FFFC);

        // reserved / PC_4 selects and ex_valid=0 never redirect
        do_reset();
        ex_valid    = 1'b1;
        branch_ctrl = 2'b11;
        pc_imm      = 32'h0000_0500;
        pc_immrs1   = 32'h0000_0600;
        wait_acc(2);
        branch_ctrl = 2'b00;
        wait_acc(3);
        ex_valid    = 1'b0;
        branch_ctrl = 2'b01;
        wait_acc(4);
        chk("nr_a1", acc_q[1], 32'h0000_0004);
        chk("nr_a2", acc_q[2], 32'h0000_0008);
        chk("nr_a3", acc_q[3], 32'h0000_000C);
        chk("nr_fcnt", 32'(flush_cnt), 32'd0);
        branch_ctrl = 2'b00;

        // redirect beats stall: full stalled buffer is invalidated
        do_reset();
        wait_acc(1);
        @(posedge clk);
        #1;
        bus.stall = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("sr_full", 32'(bus.if_valid), 32'd1);
        redir(2'b01, 32'h0000_0700, 32'h0);
        @(negedge clk);
        chk("sr_clr", 32'(bus.if_valid), 32'd0);
        chk("sr_req", 32'(bus.im_req), 32'd1);
        chk("sr_addr", bus.im_addr, 32'h0000_0700);
        @(posedge clk);
        #1;
        bus.stall = 1'b0;
        wait_dq(1);
        chk("sr_dpc", dpc_q[0], 32'h0000_0700);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-004 SHALL have port ex_valid, input, 1 bit, qualifying branch_ctrl/targets from EX this cycle.
REQ-005 SHALL have port branch_ctrl, input, 2 bits, next-PC select: 00 PC_4, 01 PC_IMM, 10 PC_IMMRS1, 11 reserved, treated as PC_4.
REQ-006 SHALL have port pc_imm, input, 32 bits, PC-relative target (branch/JAL).
REQ-007 SHALL have port pc_immrs1, input, 32 bits, register-relative target (JALR).
REQ-008 SHALL have port stall, input, 1 bit, ID hazard stall; decode does not consume if_* this cycle.
REQ-009 SHALL have ports im_req (output, 1 bit), im_addr (output, 32 bits), im_gnt (input, 1 bit): instruction-memory request, accepted when im_req and im_gnt are both high.
REQ-010 SHALL have ports im_rvalid (input, 1 bit) and im_rdata (input, 32 bits): read response, one per accepted request, at least one cycle after acceptance.
REQ-011 SHALL have ports if_valid (output, 1 bit), if_pc (output, 32 bits) and if_inst (output, 32 bits): fetched instruction presented to ID.
REQ-012 SHALL have port flush, output, 1 bit: registered one-cycle pulse that kills the IF/ID stage.

Function
REQ-013 SHALL have states BOOT, REQ, WAIT and DRAIN, with at most one memory request outstanding.
REQ-014 BOOT SHALL last one cycle after reset release, then go to REQ with fetch_pc = RESET_PC.
REQ-015 REQ SHALL drive im_req=1 and im_addr=fetch_pc; on im_gnt it SHALL go to WAIT and latch req_pc = fetch_pc.
REQ-016 REQ SHALL deassert im_req while the holding buffer is full and stall=1.
REQ-017 On im_rvalid in WAIT, the controller SHALL load {req_pc, im_rdata} into the 1-entry holding buffer, set fetch_pc = req_pc+4, and go to REQ.
REQ-018 Responses arriving during stall SHALL be held and not lost.
REQ-019 The holding buffer drives if_valid/if_pc/if_inst; it SHALL be cleared when consumed (if_valid & ~stall) and refilled in the same cycle by a simultaneous response.
REQ-020 A redirect SHALL be ex_valid with branch_ctrl 01 (target pc_imm) or 10 (target pc_immrs1 with bit0 cleared); target bits[1:0] SHALL be forced to 00.
REQ-021 On redirect, fetch_pc SHALL become the target, the buffer SHALL be invalidated, and flush SHALL be 1 on the next cycle only.
REQ-022 A redirect in REQ whose request is granted the same cycle SHALL go to DRAIN, not WAIT.
REQ-023 A redirect in WAIT without im_rvalid SHALL go to DRAIN; a redirect in WAIT with im_rvalid SHALL discard that data and go to REQ.
REQ-024 DRAIN SHALL hold im_req=0, discard the next im_rvalid, then go to REQ with the redirect target.
REQ-025 A redirect during DRAIN SHALL overwrite the pending target and remain in DRAIN.
REQ-026 A redirect SHALL take priority over stall: the buffer is invalidated even when stall=1.
REQ-027 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
REQ-028 ex_valid=0, or branch_ctrl 00/11, SHALL cause no redirect.

Reset
REQ-029 While rst_n=0 on a clock edge: state=BOOT, fetch_pc=RESET_PC, im_req=0, if_valid=0, flush=0, if_pc=0, if_inst=0, with no response tracking.
REQ-030 Reset mid-WAIT SHALL drop the outstanding request; the memory is reset by the same rst_n.

Structure
REQ-031 A shared package SHALL hold the PC_4/PC_IMM/PC_IMMRS1 select encodings (shared with the branch control logic), the fetch-state enum and the NOP constant 32'h0000_0013.
REQ-032 The holding buffer SHALL be one sub-module, ifetch_buf (1-entry valid/data register with load/consume/clear).

Verification
REQ-033 Reset then im_gnt always 1 and rvalid one cycle after grant -> im_addr 0,4,8,... and if_valid with if_pc 0,4,8.
REQ-034 stall=1 for 3 cycles while a response arrives -> if_inst held, no new im_req, and fetch resumes at the next PC after stall drops.
REQ-035 branch_ctrl=01, pc_imm=32'h100 while in WAIT -> flush pulses once, the stale rdata is discarded, and the next im_addr is 32'h100.
REQ-036 branch_ctrl=10, pc_immrs1=32'h203 -> next im_addr is 32'h200.
REQ-037 Redirect to 32'h40, then a redirect to 32'h80 while in DRAIN -> the first fetch after the drain is 32'h80.
REQ-038 fetch_pc=32'hFFFF_FFFC, then a response -> the next im_addr is 32'h0000_0000.
